// File: rtl/ecies_pkg.sv
// Shared types and constants for the ECIES hash-core arbiter.
// Client index map, FSM state encoding and a width helper.
package ecies_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int CL_ENC_MAC = 0;
    localparam int CL_DEC_MAC = 1;
    localparam int CL_ENC_KDF = 2;
    localparam int CL_DEC_KDF = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ecies_hash_arbiter_rr_picker.sv
// Combinational winner select over the pending vector.
// Round-robin from a pointer, or fixed lowest-index priority.
module rr_picker #(
    parameter int N       = 4,
    parameter int GW      = 2,
    parameter bit RR_MODE = 1'b1
) (
    input  logic [N-1:0]  i_pending,
    input  logic [GW-1:0] i_rr_ptr,
    output logic [GW-1:0] o_winner,
    output logic          o_found
);

    int w_base;
    int w_j;

    // Walk offsets high to low so the nearest pending index wins last
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_j      = 0;
        w_base   = RR_MODE ? int'(i_rr_ptr) : 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (w_base + k) % N;
            if (i_pending[w_j[GW-1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_j[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/ecies_hash_arbiter.sv
// Shares one hash core among the ECIES MAC/KDF requesters.
// Buffers single-cycle requests, arbitrates, and guards with a watchdog.
module ecies_hash_arbiter
    import ecies_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int MSG_WIDTH      = 80,
    parameter int HASH_WIDTH     = 512,
    parameter bit RR_MODE        = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = clog2(NUM_CLIENTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CLIENTS-1:0]         req_go,
    input  logic [NUM_CLIENTS*MSG_WIDTH-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]         req_done,
    output logic                           req_err,
    output logic [HASH_WIDTH-1:0]          req_digest,
    output logic [NUM_CLIENTS-1:0]         req_overflow,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy,
    input  logic                           hash_ready,
    output logic                           hash_go,
    output logic [MSG_WIDTH-1:0]           hash_msg,
    input  logic                           hash_done,
    input  logic [HASH_WIDTH-1:0]          hash_digest
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] LAST_ID = GW'(NUM_CLIENTS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [NUM_CLIENTS-1:0] r_pend;
    logic [NUM_CLIENTS-1:0] r_ovf;
    logic [MSG_WIDTH-1:0]   r_buf [NUM_CLIENTS];
    logic [GW-1:0]          r_ptr;
    logic [GW-1:0]          r_gid;
    logic [CW-1:0]          r_cnt;
    logic                   r_err;
    logic [GW-1:0]          w_win;
    logic                   w_found;
    logic                   w_grant;
    logic                   w_timeout;

    rr_picker #(
        .N       (NUM_CLIENTS),
        .GW      (GW),
        .RR_MODE (RR_MODE)
    ) u_pick (
        .i_pending (r_pend),
        .i_rr_ptr  (r_ptr),
        .o_winner  (w_win),
        .o_found   (w_found)
    );

    assign w_grant   = (r_state == ST_IDLE) && w_found && hash_ready;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        hash_go  = 1'b0;
        req_done = '0;
        req_err  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                hash_go = 1'b1;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (hash_done || w_timeout) w_next = ST_DONE;
            end
            ST_DONE: begin
                req_done[r_gid] = 1'b1;
                req_err         = r_err;
                w_next          = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend     <= '0;
            r_ovf      <= '0;
            r_ptr      <= '0;
            r_gid      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            hash_msg   <= '0;
            req_digest <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) r_buf[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (req_go[i]) begin
                    if (r_pend[i]) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_pend[i] <= 1'b1;
                        r_buf[i]  <= req_data[i*MSG_WIDTH +: MSG_WIDTH];
                    end
                end
            end
            // Granted client leaves the pending set, so it may queue again
            if (w_grant) begin
                r_pend[w_win] <= 1'b0;
                r_gid         <= w_win;
                hash_msg      <= r_buf[w_win];
            end
            if (r_state == ST_ISSUE) r_cnt <= '0;
            else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
            if (r_state == ST_WAIT) begin
                if (hash_done) begin
                    req_digest <= hash_digest;
                    r_err      <= 1'b0;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == ST_DONE) begin
                r_ptr <= (r_gid == LAST_ID) ? '0 : r_gid + 1'b1;
            end
        end
    end

    assign req_overflow = r_ovf;
    assign grant_id     = r_gid;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ecies_hash_arbiter.sv
// Bench for ecies_hash_arbiter: round-robin and fixed-priority instances,
// table-driven arbitration rows plus hand sequences for timing corners.
module tb_ecies_hash_arbiter;

    localparam int N  = 4;
    localparam int MW = 80;
    localparam int HW = 512;
    localparam logic [MW-1:0] MSG1 = 80'h0000_1234_5678_9ABC_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    go    [2];
    logic [N*MW-1:0] data  [2];
    logic            rdy   [2];
    logic            hdone [2];
    logic [HW-1:0]   hdig  [2];
    logic [N-1:0]    done  [2];
    logic [N-1:0]    ovf   [2];
    logic            err   [2];
    logic [HW-1:0]   dig   [2];
    logic [1:0]      gid   [2];
    logic            busy  [2];
    logic            hgo   [2];
    logic [MW-1:0]   hmsg  [2];

    ecies_hash_arbiter #(
        .NUM_CLIENTS(N), .MSG_WIDTH(MW), .HASH_WIDTH(HW),
        .RR_MODE(1'b1), .TIMEOUT_CYCLES(16)
    ) u_rr (
        .clk(clk), .rst(rst), .req_go(go[0]), .req_data(data[0]),
        .req_done(done[0]), .req_err(err[0]), .req_digest(dig[0]),
        .req_overflow(ovf[0]), .grant_id(gid[0]), .busy(busy[0]),
        .hash_ready(rdy[0]), .hash_go(hgo[0]), .hash_msg(hmsg[0]),
        .hash_done(hdone[0]), .hash_digest(hdig[0])
    );

    ecies_hash_arbiter #(
        .NUM_CLIENTS(N), .MSG_WIDTH(MW), .HASH_WIDTH(HW),
        .RR_MODE(1'b0), .TIMEOUT_CYCLES(16)
    ) u_fp (
        .clk(clk), .rst(rst), .req_go(go[1]), .req_data(data[1]),
        .req_done(done[1]), .req_err(err[1]), .req_digest(dig[1]),
        .req_overflow(ovf[1]), .grant_id(gid[1]), .busy(busy[1]),
        .hash_ready(rdy[1]), .hash_go(hgo[1]), .hash_msg(hmsg[1]),
        .hash_done(hdone[1]), .hash_digest(hdig[1])
    );

    typedef struct {
        int          inst;
        logic [1:0]  id;
        logic [MW-1:0] msg;
    } gexp_t;

    typedef struct {
        int          inst;
        logic [N-1:0] vec;
        logic        err;
        logic [HW-1:0] dig;
    } dexp_t;

    typedef struct {
        int         inst;
        logic [3:0] mask;
        int         n;
        logic [7:0] ord;
        int         lat;
        int         hold;
    } row_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int go_t   [2];
    int done_t [2];
    logic [HW-1:0] last_dig [2];

    int            ccnt [2];
    bit            cen  [2];
    int            clat [2];
    logic [MW-1:0] cmsg [2];

    function automatic logic [HW-1:0] mdig(input logic [MW-1:0] m);
        logic [HW-1:0] a;
        a = {64{8'hA5}};
        return a ^ {{(HW-MW){1'b0}}, m ^ MSG1};
    endfunction

    function automatic logic [MW-1:0] pay(input int r, input int i);
        return {8'(r), 8'(i), 64'hDEAD_BEEF_0000_0000 + 64'(r * 16 + i)};
    endfunction

    task automatic chk(input string name, input logic [HW-1:0] act,
                       input logic [HW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_serve(input int k, input int id,
                                input logic [MW-1:0] msg, input logic e);
        gexp_t g;
        dexp_t d;
        g.inst = k;
        g.id   = 2'(id);
        g.msg  = msg;
        d.inst = k;
        d.vec  = 4'(1 << id);
        d.err  = e;
        d.dig  = e ? last_dig[k] : mdig(msg);
        if (!e) last_dig[k] = mdig(msg);
        gq.push_back(g);
        dq.push_back(d);
    endtask

    task automatic send(input int k, input logic [N-1:0] m,
                        input logic [N*MW-1:0] d);
        go[k]   = m;
        data[k] = d;
        @(negedge clk);
        go[k] = '0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int t;
        t = 0;
        while ((gq.size() != 0 || dq.size() != 0 || busy[0] || busy[1])
               && t < budget) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= budget) begin
            bad++;
            $display("FAIL drain_%s: timed out with %0d grants %0d dones left",
                     tag, gq.size(), dq.size());
            gq.delete();
            dq.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_done", done[k], 0);
            chk("rst_err", err[k], 0);
            chk("rst_dig", dig[k], 0);
            chk("rst_ovf", ovf[k], 0);
            chk("rst_gid", gid[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_hgo", hgo[k], 0);
            chk("rst_hmsg", hmsg[k], 0);
            last_dig[k] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural hash core: done pulse clat cycles after the start
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            hdone[k] = 1'b0;
            if (ccnt[k] > 0) begin
                ccnt[k] = ccnt[k] - 1;
                if (ccnt[k] == 0) begin
                    hdone[k] = 1'b1;
                    hdig[k]  = mdig(cmsg[k]);
                end
            end
            if (hgo[k] && cen[k]) begin
                ccnt[k] = clat[k];
                cmsg[k] = hmsg[k];
            end
        end
    end

    always @(negedge clk) begin
        gexp_t g;
        dexp_t d;
        for (int k = 0; k < 2; k++) begin
            if (hgo[k] === 1'b1) begin
                go_t[k] = cyc;
                if (gq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_go: inst %0d grant %0d", k, gid[k]);
                end else begin
                    g = gq.pop_front();
                    chk("go_inst", k, g.inst);
                    chk("go_id", gid[k], g.id);
                    chk("go_msg", hmsg[k], g.msg);
                end
            end
            if (done[k] !== '0) begin
                done_t[k] = cyc;
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: inst %0d done %b", k, done[k]);
                end else begin
                    d = dq.pop_front();
                    chk("done_inst", k, d.inst);
                    chk("done_vec", done[k], d.vec);
                    chk("done_err", err[k], d.err);
                    chk("done_dig", dig[k], d.dig);
                end
            end
        end
    end

    row_t rows [7];

    initial begin
        int c;
        int t;
        logic [N*MW-1:0] d;

        rows[0] = '{0, 4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 10, 0};
        rows[1] = '{0, 4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 3, 0};
        rows[2] = '{0, 4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2}, 5, 4};
        rows[3] = '{0, 4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0}, 7, 0};
        rows[4] = '{0, 4'b1010, 2, {2'd0, 2'd0, 2'd1, 2'd3}, 2, 0};
        rows[5] = '{1, 4'b1110, 3, {2'd0, 2'd3, 2'd2, 2'd1}, 4, 0};
        rows[6] = '{1, 4'b1001, 2, {2'd0, 2'd0, 2'd3, 2'd0}, 6, 0};

        for (int k = 0; k < 2; k++) begin
            go[k] = '0; data[k] = '0; rdy[k] = 1'b1;
            hdone[k] = 1'b0; hdig[k] = '0;
            ccnt[k] = 0; cen[k] = 1'b1; clat[k] = 10; cmsg[k] = '0;
            go_t[k] = 0; done_t[k] = 0; last_dig[k] = '0;
        end
        @(negedge clk);
        do_reset();

        // Single request from client 2 with known latency
        clat[0] = 10;
        expect_serve(0, 2, MSG1, 1'b0);
        c = cyc;
        send(0, 4'b0100, {MW'(0), MSG1, MW'(0), MW'(0)});
        wait_drain(100, "single");
        chk("start_lat", go_t[0] - c, 2);
        chk("done_lat", done_t[0] - go_t[0], 11);
        chk("digest_held", dig[0], {64{8'hA5}});

        do_reset();

        for (int r = 0; r < 7; r++) begin
            int k;
            k = rows[r].inst;
            clat[k] = rows[r].lat;
            d = '0;
            for (int i = 0; i < N; i++) d[i*MW +: MW] = pay(r, i);
            for (int j = 0; j < rows[r].n; j++) begin
                int id;
                id = int'(rows[r].ord[2*j +: 2]);
                expect_serve(k, id, pay(r, id), 1'b0);
            end
            if (rows[r].hold > 0) rdy[k] = 1'b0;
            send(k, rows[r].mask, d);
            if (rows[r].hold > 0) begin
                repeat (rows[r].hold) @(negedge clk);
                chk("ready_low_busy", busy[k], 0);
                rdy[k] = 1'b1;
            end
            wait_drain(400, "row");
            chk("row_ovf", ovf[k], 0);
        end

        // Double go from client 1 while client 0 is being served
        clat[0] = 10;
        expect_serve(0, 0, pay(20, 0), 1'b0);
        expect_serve(0, 1, pay(20, 1), 1'b0);
        send(0, 4'b0001, {MW'(0), MW'(0), MW'(0), pay(20, 0)});
        t = 0;
        while (gq.size() > 1 && t < 50) begin @(negedge clk); t++; end
        chk("ovf_wait_go", (t < 50), 1);
        send(0, 4'b0010, {MW'(0), MW'(0), pay(20, 1), MW'(0)});
        send(0, 4'b0010, {MW'(0), MW'(0), pay(21, 1), MW'(0)});
        wait_drain(200, "overflow");
        chk("ovf_vec", ovf[0], 4'b0010);

        // Core never answers: watchdog abort keeps the old digest
        cen[0] = 1'b0;
        expect_serve(0, 3, pay(22, 3), 1'b1);
        send(0, 4'b1000, {pay(22, 3), MW'(0), MW'(0), MW'(0)});
        wait_drain(200, "timeout");
        chk("timeout_lat", done_t[0] - go_t[0], 17);
        chk("timeout_dig", dig[0], mdig(pay(20, 1)));
        cen[0] = 1'b1;

        // Fixed priority: client 0 re-requests in each of its DONE cycles
        clat[1] = 3;
        for (int s = 0; s < 4; s++) expect_serve(1, 0, pay(30 + s, 0), 1'b0);
        for (int i = 1; i < N; i++) expect_serve(1, i, pay(30, i), 1'b0);
        d = '0;
        for (int i = 0; i < N; i++) d[i*MW +: MW] = pay(30, i);
        send(1, 4'b1111, d);
        for (int s = 1; s < 4; s++) begin
            t = 0;
            while (done[1][0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
            chk("starve_wait_done", (t < 200), 1);
            d[0 +: MW] = pay(30 + s, 0);
            send(1, 4'b0001, d);
        end
        wait_drain(400, "starve");

        // Reset during WAIT abandons the operation and the queued client
        clat[0] = 10;
        gq.push_back('{0, 2'd1, pay(40, 1)});
        send(0, 4'b0010, {MW'(0), MW'(0), pay(40, 1), MW'(0)});
        send(0, 4'b0100, {MW'(0), pay(40, 2), MW'(0), MW'(0)});
        t = 0;
        while (gq.size() != 0 && t < 50) begin @(negedge clk); t++; end
        chk("rst_wait_go", (t < 50), 1);
        repeat (3) @(negedge clk);
        chk("rst_in_wait", busy[0], 1);
        do_reset();
        repeat (15) @(negedge clk);
        chk("post_rst_busy", busy[0], 0);
        chk("post_rst_done", done[0], 0);
        chk("post_rst_dig", dig[0], 0);
        chk("post_rst_ovf", ovf[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
